cache_fill_arbiter: RTL

Memory-side responder for the I-cache and D-cache miss/store request interface. It arbitrates between I-cache and D-cache requests, with the D-cache winning. For a read miss it issues 8 consecutive word reads of one 16-byte block to the 4-cycle pipelined main memory and streams the returned words back with an index. Write-through stores are forwarded to memory as single-cycle writes. It sits between the two cache controllers and main memory inside the CPU.

---
 rtl/cache_fill_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cache_fill_arbiter.sv
// Memory-side responder for I/D cache misses and write-through stores.
// D-cache wins arbitration; read misses stream a full block back word by word.
module cache_fill_arbiter #(
    parameter int unsigned WORDS   = 8,
    parameter int unsigned MEM_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        fill_valid,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_idx,
    output logic        fill_to_d,
    output logic        fill_done,
    output logic        wr_ack,
    output logic        busy,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid
);
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = $clog2(WORDS);
    localparam int unsigned BASE_W = ADDR_W - CNT_W - 1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t              state, state_nxt;
    logic [CNT_W:0]      iss_cnt, iss_cnt_nxt;
    logic [CNT_W-1:0]    ret_cnt, ret_cnt_nxt;
    logic                owner, owner_nxt;
    logic [BASE_W-1:0]   base, base_nxt;
    logic [ADDR_W-1:0]   wr_addr, wr_addr_nxt;
    logic [15:0]         wr_data, wr_data_nxt;

    // Word-offset bits of the I-cache address and the latency parameter feed no logic.
    logic unused_bits;
    assign unused_bits = ^{i_addr[3:0], 32'(MEM_LAT)};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            iss_cnt <= '0;
            ret_cnt <= '0;
            owner   <= 1'b0;
            base    <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state   <= state_nxt;
            iss_cnt <= iss_cnt_nxt;
            ret_cnt <= ret_cnt_nxt;
            owner   <= owner_nxt;
            base    <= base_nxt;
            wr_addr <= wr_addr_nxt;
            wr_data <= wr_data_nxt;
        end
    end

    // Next state and output decode
    always_comb begin
        state_nxt   = state;
        iss_cnt_nxt = iss_cnt;
        ret_cnt_nxt = ret_cnt;
        owner_nxt   = owner;
        base_nxt    = base;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
        fill_valid  = 1'b0;
        fill_data   = '0;
        fill_idx    = '0;
        fill_to_d   = 1'b0;
        fill_done   = 1'b0;
        wr_ack      = 1'b0;
        busy        = 1'b0;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        unique case (state)
            IDLE: begin
                if (d_req || i_req) begin
                    iss_cnt_nxt = '0;
                    ret_cnt_nxt = '0;
                    wr_addr_nxt = d_addr;
                    wr_data_nxt = d_wdata;
                end
                if (d_req) begin
                    owner_nxt = 1'b1;
                    base_nxt  = d_addr[ADDR_W-1:CNT_W+1];
                    state_nxt = d_wr ? WRITE : FILL;
                end else if (i_req) begin
                    owner_nxt = 1'b0;
                    base_nxt  = i_addr[ADDR_W-1:CNT_W+1];
                    state_nxt = FILL;
                end
            end
            FILL: begin
                busy      = 1'b1;
                fill_to_d = owner;
                fill_idx  = ret_cnt;
                fill_data = mem_rdata;
                // Issue side saturates once the whole block has been requested.
                if (iss_cnt < (CNT_W+1)'(WORDS)) begin
                    mem_en      = 1'b1;
                    mem_addr    = {base, iss_cnt[CNT_W-1:0], 1'b0};
                    iss_cnt_nxt = iss_cnt + (CNT_W+1)'(1);
                end
                if (mem_rvalid) begin
                    fill_valid  = 1'b1;
                    ret_cnt_nxt = ret_cnt + CNT_W'(1);
                    if (ret_cnt == CNT_W'(WORDS - 1)) begin
                        fill_done = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            WRITE: begin
                busy      = 1'b1;
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
                wr_ack    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
